// File: rtl/pot_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eq_pot_pkg
//  Description : Shared types and constants for the pot scan sequencer:
//                FSM states, pot indices and the pot-to-A2D channel map.
//  Revision    : 1.0 - initial release
// ============================================================================
package eq_pot_pkg;

    localparam int NUM_POTS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        LP  = 3'd0,
        B1  = 3'd1,
        B2  = 3'd2,
        B3  = 3'd3,
        HP  = 3'd4,
        VOL = 3'd5
    } pot_idx_t;

    // A2D channel wired to each pot, indexed by pot_idx_t
    localparam logic [2:0] CH_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

endpackage
`default_nettype wire

// File: rtl/pot_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pot_scan_sequencer_if
//  Description : Start/complete handshake between the pot scan sequencer
//                (master) and the shared SPI A2D interface block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pot_scan_sequencer_if;

    logic        a2d_strt;
    logic [2:0]  a2d_chnnl;
    logic        a2d_cnv_cmplt;
    logic [11:0] a2d_res;

    modport master (
        output a2d_strt,
        output a2d_chnnl,
        input  a2d_cnv_cmplt,
        input  a2d_res
    );

    modport slave (
        input  a2d_strt,
        input  a2d_chnnl,
        output a2d_cnv_cmplt,
        output a2d_res
    );

endinterface
`default_nettype wire

// File: rtl/pot_scan_sequencer_iir_step.sv
`default_nettype none
// ============================================================================
//  Module      : pot_iir_step
//  Description : One smoothing step, nxt = (3*cur + sample) >> 2, computed on
//                a 14-bit intermediate and truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module pot_iir_step (
    input  logic [11:0] cur_val,
    input  logic [11:0] sample,
    output logic [11:0] nxt_val
);

    // 3*4095 + 4095 fits in 14 bits, so the sum never overflows before the shift
    assign nxt_val = 12'(({2'b00, cur_val} * 14'd3 + {2'b00, sample}) >> 2);

endmodule
`default_nettype wire

// File: rtl/pot_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pot_scan_sequencer
//  Description : Round-robin scheduler for the shared A2D reading the six
//                slide pots (LP, B1, B2, B3, HP, VOL). Issues one conversion
//                per pot, captures results into per-band gain registers,
//                flags conversions that never complete.
//                Optional build macro POT_IIR_EN: smooth every accepted
//                result as pot <= (3*pot + res) >> 2 instead of direct load.
//  Revision    : 1.0 - initial release
// ============================================================================
module pot_scan_sequencer
    import eq_pot_pkg::*;
#(
    parameter int          SCAN_GAP = 1024,
    parameter int          TIMEOUT  = 4096,
    parameter logic [11:0] RST_VAL  = 12'h800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_en,
    pot_scan_sequencer_if.master a2d,
    output logic [11:0]          LP_pot,
    output logic [11:0]          B1_pot,
    output logic [11:0]          B2_pot,
    output logic [11:0]          B3_pot,
    output logic [11:0]          HP_pot,
    output logic [11:0]          VOL_pot,
    output logic                 scan_done,
    output logic                 tmo_err,
    output logic [2:0]           tmo_idx
);

    localparam int GAP_W = $clog2(SCAN_GAP + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             state_q,     state_d;
    pot_idx_t           idx_q,       idx_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
    logic [2:0]         chnnl_q,     chnnl_d;
    logic               scan_done_q, scan_done_d;
    logic               tmo_err_q,   tmo_err_d;
    logic [2:0]         tmo_idx_q,   tmo_idx_d;
    logic [11:0]        pot_q [NUM_POTS];
    logic [11:0]        pot_d [NUM_POTS];
    logic [11:0]        w_pot_upd;

`ifdef POT_IIR_EN
    pot_iir_step u_iir (
        .cur_val (pot_q[idx_q]),
        .sample  (a2d.a2d_res),
        .nxt_val (w_pot_upd)
    );
`else
    assign w_pot_upd = a2d.a2d_res;
`endif

    // Next-state, counters and capture logic for the scan FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        chnnl_d     = chnnl_q;
        scan_done_d = 1'b0;
        tmo_err_d   = tmo_err_q;
        tmo_idx_d   = tmo_idx_q;
        pot_d       = pot_q;

        case (state_q)
            IDLE: begin
                if (scan_en) state_d = START;
            end
            START: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A completion on the last allowed cycle still counts as success
                if (a2d.a2d_cnv_cmplt) begin
                    pot_d[idx_q] = w_pot_upd;
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    tmo_idx_d = idx_q;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_W'(SCAN_GAP - 1)) begin
                    if (idx_q == VOL) begin
                        scan_done_d = 1'b1;
                        idx_d       = LP;
                    end else begin
                        idx_d = pot_idx_t'(idx_q + 3'd1);
                    end
                    state_d = scan_en ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Channel is latched on entry to START and held until the next one
        if (state_d == START) chnnl_d = CH_MAP[idx_d];
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= LP;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            chnnl_q     <= CH_MAP[0];
            scan_done_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            tmo_idx_q   <= 3'd0;
            pot_q       <= '{default: RST_VAL};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            chnnl_q     <= chnnl_d;
            scan_done_q <= scan_done_d;
            tmo_err_q   <= tmo_err_d;
            tmo_idx_q   <= tmo_idx_d;
            pot_q       <= pot_d;
        end
    end

    assign a2d.a2d_strt  = (state_q == START);
    assign a2d.a2d_chnnl = chnnl_q;
    assign scan_done     = scan_done_q;
    assign tmo_err       = tmo_err_q;
    assign tmo_idx       = tmo_idx_q;
    assign LP_pot        = pot_q[LP];
    assign B1_pot        = pot_q[B1];
    assign B2_pot        = pot_q[B2];
    assign B3_pot        = pot_q[B3];
    assign HP_pot        = pot_q[HP];
    assign VOL_pot       = pot_q[VOL];

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pot_scan_sequencer
//  Description : Directed self-checking bench for pot_scan_sequencer with a
//                behavioural A2D model (fixed latency, per-channel silence).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pot_scan_sequencer;

    localparam int SCAN_GAP = 4;
    localparam int TIMEOUT  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;
    logic        scan_done, tmo_err;
    logic [2:0]  tmo_idx;

    int vectors    = 0;
    int miscompares = 0;

    // A2D model controls (written by the test sequence only)
    bit          model_on  = 1'b0;
    int          silent_ch = -1;
    int          model_lat = 20;
    logic [11:0] model_val = 12'h000;
    logic        man_cmplt = 1'b0;
    logic [11:0] man_res   = 12'h000;

    // A2D model outputs (written by the model process only)
    logic        mdl_cmplt;
    logic [11:0] mdl_res;

    int cyc = 0;
    int strt_cyc_q[$];
    int strt_ch_q[$];

    pot_scan_sequencer_if a2d_if();

    assign a2d_if.a2d_cnv_cmplt = mdl_cmplt | man_cmplt;
    assign a2d_if.a2d_res       = man_cmplt ? man_res : mdl_res;

    pot_scan_sequencer #(
        .SCAN_GAP (SCAN_GAP),
        .TIMEOUT  (TIMEOUT),
        .RST_VAL  (12'h800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .a2d       (a2d_if),
        .LP_pot    (LP_pot),
        .B1_pot    (B1_pot),
        .B2_pot    (B2_pot),
        .B3_pot    (B3_pot),
        .HP_pot    (HP_pot),
        .VOL_pot   (VOL_pot),
        .scan_done (scan_done),
        .tmo_err   (tmo_err),
        .tmo_idx   (tmo_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every start pulse with its cycle and channel
    always @(negedge clk) begin
        if (a2d_if.a2d_strt) begin
            strt_cyc_q.push_back(cyc);
            strt_ch_q.push_back(int'(a2d_if.a2d_chnnl));
        end
    end

    // A2D model: a strt seen in cycle n yields a cmplt in cycle n+model_lat
    initial begin : a2d_model
        bit pend;
        int remain;
        pend      = 1'b0;
        remain    = 0;
        mdl_cmplt = 1'b0;
        mdl_res   = 12'h000;
        forever begin
            @(negedge clk);
            mdl_cmplt = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    remain--;
                    if (remain == 0) begin
                        pend      = 1'b0;
                        mdl_cmplt = 1'b1;
                        mdl_res   = model_val;
                    end
                end
                if (a2d_if.a2d_strt && model_on && int'(a2d_if.a2d_chnnl) != silent_ch) begin
                    pend   = 1'b1;
                    remain = model_lat;
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        scan_en   = 1'b0;
        man_cmplt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_strt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a2d_if.a2d_strt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int base;
        rst     = 1'b1;
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (a2d_if.a2d_strt !== 1'b0 || a2d_if.a2d_chnnl !== 3'd1 || scan_done !== 1'b0 ||
            tmo_err !== 1'b0 || tmo_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: strt=%b ch=%0d done=%b err=%b idx=%0d, want 0 1 0 0 0",
                     a2d_if.a2d_strt, a2d_if.a2d_chnnl, scan_done, tmo_err, tmo_idx);
        end
        vectors++;
        if ({LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot} !== {6{12'h800}}) begin
            miscompares++;
            $display("FAIL reset_pots: %h %h %h %h %h %h, want all 800",
                     LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot);
        end
        rst      = 1'b0;
        model_on = 1'b1;
        base     = strt_ch_q.size();
        repeat (50) @(negedge clk);
        vectors++;
        if (strt_ch_q.size() != base || LP_pot !== 12'h800 || VOL_pot !== 12'h800) begin
            miscompares++;
            $display("FAIL idle_no_strt: %0d strts, LP=%h VOL=%h, want 0 strts and 800",
                     strt_ch_q.size() - base, LP_pot, VOL_pot);
        end
    endtask

    task automatic test_scan();
        int base;
        bit ok;
        int exp_ch [6] = '{1, 0, 4, 2, 3, 7};
        do_reset();
        model_on  = 1'b1;
        silent_ch = -1;
        model_lat = 20;
        model_val = 12'h123;
        base      = strt_ch_q.size();
        scan_en   = 1'b1;
        wait_done(400, ok);
        @(negedge clk);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL scan_done_seen: no pulse in 400 cycles, want one");
        end
        vectors++;
        if ({LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot} !== {6{12'h123}}) begin
            miscompares++;
            $display("FAIL scan_pots: %h %h %h %h %h %h, want all 123",
                     LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot);
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (strt_ch_q.size() < base + 6 || strt_ch_q[base + k] != exp_ch[k]) begin
                miscompares++;
                $display("FAIL chan_seq[%0d]: got %0d, want %0d", k,
                         (strt_ch_q.size() > base + k) ? strt_ch_q[base + k] : -1, exp_ch[k]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (strt_cyc_q.size() < base + 6 ||
                strt_cyc_q[base + k + 1] - strt_cyc_q[base + k] != 1 + 20 + SCAN_GAP) begin
                miscompares++;
                $display("FAIL strt_spacing[%0d]: got %0d, want %0d", k,
                         (strt_cyc_q.size() > base + k + 1) ?
                         strt_cyc_q[base + k + 1] - strt_cyc_q[base + k] : -1, 1 + 20 + SCAN_GAP);
            end
        end
        scan_en = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        bit found;
        int k;
        do_reset();
        model_on  = 1'b1;
        silent_ch = 4;
        model_lat = 20;
        model_val = 12'h456;
        scan_en   = 1'b1;
        found     = 1'b0;
        for (int s = 0; s < 6 && !found; s++) begin
            wait_strt(100, ok);
            if (ok && a2d_if.a2d_chnnl == 3'd4) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL tmo_find_ch4: no strt on channel 4, want one");
        end
        // WAIT occupies the TIMEOUT cycles after strt; the flag shows the cycle after
        k = 0;
        while (tmo_err !== 1'b1 && k < TIMEOUT + 10) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (k != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL tmo_latency: got %0d cycles, want %0d", k, TIMEOUT + 1);
        end
        vectors++;
        if (tmo_idx !== 3'd2 || B2_pot !== 12'h800 || B1_pot !== 12'h456) begin
            miscompares++;
            $display("FAIL tmo_state: idx=%0d B2=%h B1=%h, want 2 800 456", tmo_idx, B2_pot, B1_pot);
        end
        wait_strt(20, ok);
        vectors++;
        if (!ok || a2d_if.a2d_chnnl !== 3'd2 || B2_pot !== 12'h800 || tmo_err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_continue: ok=%b ch=%0d B2=%h err=%b, want 1 2 800 1",
                     ok, a2d_if.a2d_chnnl, B2_pot, tmo_err);
        end
        scan_en   = 1'b0;
        silent_ch = -1;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_cmplt_at_timeout();
        bit ok;
        do_reset();
        model_on = 1'b0;
        scan_en  = 1'b1;
        wait_strt(10, ok);
        scan_en = 1'b0;
        // cmplt lands in the last WAIT cycle (tmo_cnt == TIMEOUT-1)
        repeat (TIMEOUT) @(negedge clk);
        man_res   = 12'h321;
        man_cmplt = 1'b1;
        @(negedge clk);
        man_cmplt = 1'b0;
        vectors++;
        if (!ok || LP_pot !== 12'h321 || tmo_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cmplt_at_tmo: ok=%b LP=%h err=%b, want 1 321 0", ok, LP_pot, tmo_err);
        end
        // A cmplt during GAP must be ignored
        man_res   = 12'hABC;
        man_cmplt = 1'b1;
        @(negedge clk);
        man_cmplt = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (LP_pot !== 12'h321 || B1_pot !== 12'h800) begin
            miscompares++;
            $display("FAIL cmplt_in_gap: LP=%h B1=%h, want 321 800", LP_pot, B1_pot);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_scan_en_drop();
        bit ok;
        bit found;
        int base;
        do_reset();
        model_on  = 1'b1;
        silent_ch = -1;
        model_lat = 20;
        model_val = 12'h5A5;
        scan_en   = 1'b1;
        found     = 1'b0;
        for (int s = 0; s < 6 && !found; s++) begin
            wait_strt(40, ok);
            if (ok && a2d_if.a2d_chnnl == 3'd7) found = 1'b1;
        end
        repeat (5) @(negedge clk);
        scan_en = 1'b0;
        wait_done(60, ok);
        vectors++;
        if (!found || !ok) begin
            miscompares++;
            $display("FAIL drop_done: vol_strt=%b done=%b, want 1 1", found, ok);
        end
        vectors++;
        if (VOL_pot !== 12'h5A5) begin
            miscompares++;
            $display("FAIL drop_vol: got %h, want 5a5", VOL_pot);
        end
        base = strt_ch_q.size();
        repeat (30) @(negedge clk);
        vectors++;
        if (strt_ch_q.size() != base || a2d_if.a2d_chnnl !== 3'd7) begin
            miscompares++;
            $display("FAIL drop_idle: %0d strts ch=%0d, want 0 strts ch=7",
                     strt_ch_q.size() - base, a2d_if.a2d_chnnl);
        end
        scan_en = 1'b1;
        wait_strt(5, ok);
        scan_en = 1'b0;
        vectors++;
        if (!ok || a2d_if.a2d_chnnl !== 3'd1) begin
            miscompares++;
            $display("FAIL resume_ch: ok=%b ch=%0d, want 1 1", ok, a2d_if.a2d_chnnl);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_rst_mid_wait();
        bit ok;
        do_reset();
        model_on = 1'b0;
        scan_en  = 1'b1;
        wait_strt(10, ok);
        repeat (5) @(negedge clk);
        man_res   = 12'h111;
        man_cmplt = 1'b1;
        @(negedge clk);
        man_cmplt = 1'b0;
        vectors++;
        if (!ok || LP_pot !== 12'h111) begin
            miscompares++;
            $display("FAIL pre_rst_lp: ok=%b LP=%h, want 1 111", ok, LP_pot);
        end
        wait_strt(20, ok);
        repeat (3) @(negedge clk);
        man_res   = 12'h222;
        man_cmplt = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        man_cmplt = 1'b0;
        vectors++;
        if (!ok || LP_pot !== 12'h800 || B1_pot !== 12'h800 || a2d_if.a2d_strt !== 1'b0 ||
            a2d_if.a2d_chnnl !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_mid_wait: ok=%b LP=%h B1=%h strt=%b ch=%0d, want 1 800 800 0 1",
                     ok, LP_pot, B1_pot, a2d_if.a2d_strt, a2d_if.a2d_chnnl);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_strt(5, ok);
        scan_en = 1'b0;
        vectors++;
        if (!ok || a2d_if.a2d_chnnl !== 3'd1) begin
            miscompares++;
            $display("FAIL post_rst_ch: ok=%b ch=%0d, want 1 1", ok, a2d_if.a2d_chnnl);
        end
        do_reset();
    endtask

    task automatic test_smoothing();
        bit ok;
`ifdef POT_IIR_EN
        logic [11:0] exp_lp [3] = '{12'h9FF, 12'hB7F, 12'hC9F};
`endif
        do_reset();
        model_on  = 1'b1;
        silent_ch = -1;
        model_lat = 20;
        model_val = 12'hFFF;
        scan_en   = 1'b1;
`ifdef POT_IIR_EN
        for (int p = 0; p < 3; p++) begin
            wait_done(200, ok);
            @(negedge clk);
            vectors++;
            if (!ok || LP_pot !== exp_lp[p]) begin
                miscompares++;
                $display("FAIL iir_pass[%0d]: ok=%b LP=%h, want 1 %h", p, ok, LP_pot, exp_lp[p]);
            end
        end
`else
        wait_done(200, ok);
        @(negedge clk);
        vectors++;
        if (!ok || LP_pot !== 12'hFFF || VOL_pot !== 12'hFFF) begin
            miscompares++;
            $display("FAIL direct_load: ok=%b LP=%h VOL=%h, want 1 fff fff", ok, LP_pot, VOL_pot);
        end
`endif
        scan_en = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        scan_en = 1'b0;
        test_reset();
        test_scan();
        test_timeout();
        test_cmplt_at_timeout();
        test_scan_en_drop();
        test_rst_mid_wait();
        test_smoothing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
